// File: rtl/vga_frame_fetch.sv
// vga_frame_fetch
//   Pixel source that sits between vgaController and the VGA pins. It turns
//   the controller's x/y/blank/sync timing into reads of an 8-bit grayscale
//   frame RAM. The RAM is split into two buffers so the image writer can fill
//   one while the other is shown. The stored image is upscaled by pixel
//   replication into a fixed on-screen window. Sync and blank are delayed by
//   the fetch latency so that RGB stays aligned with them.
//
// Ports
//   clk, rst              pixel clock, synchronous active-high reset
//   x, y                  current column / line from vgaController
//   blankB_in             1 = visible pixel
//   hSync_in, vSync_in    active-low syncs from vgaController
//   rd_en, rd_addr        frame RAM read strobe and address
//   rd_data               RAM data, valid MEM_LAT cycles after the request
//   frame_ready           writer pulse: the back buffer is complete
//   frame_ack             pulse: the buffers were swapped
//   buf_sel               buffer currently displayed
//   hSync, vSync, blankB  delayed copies of the timing inputs
//   r, g, b               pixel colour, 4 bits each
module vga_frame_fetch #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          IMG_W    = 160,
  parameter int          IMG_H    = 120,
  parameter int          SCALE    = 4,
  parameter int          X0       = 0,
  parameter int          Y0       = 0,
  parameter int          MEM_LAT  = 2,
  parameter int          ADDR_W   = 16,
  parameter logic [11:0] BORDER   = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              blankB_in,
  input  logic              hSync_in,
  input  logic              vSync_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              frame_ready,
  output logic              frame_ack,
  output logic              buf_sel,
  output logic              hSync,
  output logic              vSync,
  output logic              blankB,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b
);

  // The timing/flag pipeline is one stage longer than the RAM latency; the
  // output registers add the final stage.
  localparam int D  = MEM_LAT + 1;
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [31:0]       X_LO        = 32'(X0);
  localparam logic [31:0]       Y_LO        = 32'(Y0);
  localparam logic [31:0]       WIN_W       = 32'(IMG_W * SCALE);
  localparam logic [31:0]       WIN_H       = 32'(IMG_H * SCALE);
  localparam logic [31:0]       X_LAST      = 32'(X0 + IMG_W * SCALE - 1);
  localparam logic [31:0]       H_LIM       = 32'(H_ACTIVE);
  localparam logic [31:0]       V_BLANK     = 32'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_ROW    = ADDR_W'((IMG_H - 1) * IMG_W);
  localparam logic [SW-1:0]     SUB_LAST    = SW'(SCALE - 1);

  logic [31:0]       xPos, yPos;
  logic              frameStart, inWin, lineEnd, syncedCur, swapNow;
  logic              synced, pending;
  logic [ADDR_W-1:0] col, colNext, rowBase, rowBaseCur, rowBaseNext, addrNext;
  logic [SW-1:0]     subx, subxNext, suby, subyCur, subyNext;
  logic [D-1:0]      hsPipe, vsPipe, blPipe, showPipe;
  logic [3:0]        unusedLowBits;

  assign xPos          = {22'd0, x};
  assign yPos          = {22'd0, y};
  assign unusedLowBits = rd_data[3:0];

  // Window test and address counters. The counter registers hold the state
  // left by the previous window pixel; the *Cur/*Next values are what the
  // current pixel uses, so the first pixel of a line or frame already reads
  // column 0 / row 0. The window bounds use a wrapping subtraction so a
  // position left of (or above) the window falls out as a huge value.
  always_comb begin
    frameStart  = (x == '0) && (y == '0);
    inWin       = blankB_in && ((xPos - X_LO) < WIN_W) && (xPos < H_LIM) &&
                  ((yPos - Y_LO) < WIN_H);
    lineEnd     = inWin && (xPos == X_LAST);
    syncedCur   = synced || frameStart;
    rowBaseCur  = frameStart ? '0 : rowBase;
    subyCur     = frameStart ? '0 : suby;
    colNext     = col;
    subxNext    = subx;
    rowBaseNext = rowBaseCur;
    subyNext    = subyCur;
    if (inWin) begin
      if (xPos == X_LO) begin
        colNext  = '0;
        subxNext = '0;
      end else if (subx == SUB_LAST) begin
        subxNext = '0;
        colNext  = col + ADDR_W'(1);
      end else begin
        subxNext = subx + SW'(1);
      end
    end
    // The row base wraps to 0 after the last image row so it never points
    // past the buffer; the next frame start clears it anyway.
    if (lineEnd) begin
      if (subyCur == SUB_LAST) begin
        subyNext    = '0;
        rowBaseNext = (rowBaseCur == LAST_ROW) ? '0 : rowBaseCur + ROW_STEP;
      end else begin
        subyNext = subyCur + SW'(1);
      end
    end
    addrNext = (buf_sel ? FRAME_WORDS : '0) + rowBaseCur + colNext;
    // Swapping only on the first blank line keeps buf_sel stable for the
    // whole visible frame; a request arriving on that very cycle is taken.
    swapNow  = (x == '0) && (yPos == V_BLANK) && (pending || frame_ready);
  end

  // Counters, RAM request, buffer swap, timing pipeline and colour output.
  always_ff @(posedge clk) begin
    if (rst) begin
      synced    <= 1'b0;
      pending   <= 1'b0;
      col       <= '0;
      subx      <= '0;
      rowBase   <= '0;
      suby      <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      frame_ack <= 1'b0;
      buf_sel   <= 1'b0;
      hsPipe    <= '1;
      vsPipe    <= '1;
      blPipe    <= '0;
      showPipe  <= '0;
      hSync     <= 1'b1;
      vSync     <= 1'b1;
      blankB    <= 1'b0;
      r         <= 4'd0;
      g         <= 4'd0;
      b         <= 4'd0;
    end else begin
      synced    <= syncedCur;
      col       <= colNext;
      subx      <= subxNext;
      rowBase   <= rowBaseNext;
      suby      <= subyNext;
      rd_en     <= inWin && syncedCur;
      rd_addr   <= addrNext;
      frame_ack <= swapNow;
      buf_sel   <= buf_sel ^ swapNow;
      if (swapNow) begin
        pending <= 1'b0;
      end else if (frame_ready) begin
        pending <= 1'b1;
      end
      hsPipe   <= {hsPipe[D-2:0], hSync_in};
      vsPipe   <= {vsPipe[D-2:0], vSync_in};
      blPipe   <= {blPipe[D-2:0], blankB_in};
      showPipe <= {showPipe[D-2:0], inWin && syncedCur};
      hSync    <= hsPipe[D-1];
      vSync    <= vsPipe[D-1];
      blankB   <= blPipe[D-1];
      if (!blPipe[D-1]) begin
        r <= 4'd0;
        g <= 4'd0;
        b <= 4'd0;
      end else if (showPipe[D-1]) begin
        r <= rd_data[7:4];
        g <= rd_data[7:4];
        b <= rd_data[7:4];
      end else begin
        r <= BORDER[11:8];
        g <= BORDER[7:4];
        b <= BORDER[3:0];
      end
    end
  end

endmodule
